// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, FSM states and buffer entry type for the fetch controller
package fetch_pkg;

   localparam int ADDR_W  = 64;
   localparam int INSTR_W = 32;
   localparam int ENTRY_W = INSTR_W + ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DEBUG = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetched-instruction buffer with flush; flush beats push and pop
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_push,
   input  logic [ENTRY_W-1:0] i_data,
   input  logic               i_pop,
   input  logic               i_flush,
   output logic               o_full,
   output logic               o_empty,
   output logic [ENTRY_W-1:0] o_head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch FSM with debug port arbitration; FETCH_BOUNDS_CHECK_EN enables out-of-range halt
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int          MEM_SIZE   = 16,
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] imem_adr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [63:0] instr_pc,
   input  logic        dbg_req,
   input  logic [63:0] dbg_adr,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic        fetch_fault
);

   localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_SIZE * 4);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  w_pc_nxt;
   logic [ADDR_W-1:0]  w_pc_plus4;
   logic [ADDR_W-1:0]  w_pc_inc;
   logic [ADDR_W-1:0]  w_redirect_pc;
   logic               w_oob;
   logic               w_push;
   logic               w_full;
   logic               w_empty;
   logic               r_dbg_rvalid;
   logic [INSTR_W-1:0] r_dbg_rdata;
   fetch_entry_t       w_entry_in;
   fetch_entry_t       w_head;

   assign w_pc_plus4    = r_pc + 64'd4;
   assign w_redirect_pc = redirect_pc & ~64'h3;

`ifdef FETCH_BOUNDS_CHECK_EN
   logic r_fault;

   assign w_oob    = (r_pc >= MEM_BYTES);
   assign w_pc_inc = w_pc_plus4;

   // Sticky until a redirect, which is also the only way out of HALT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_fault <= 1'b0;
      else if (redirect_valid)
         r_fault <= 1'b0;
      else if (r_state == FETCH && !w_full && w_oob)
         r_fault <= 1'b1;
   end

   assign fetch_fault = r_fault;
`else
   assign w_oob       = 1'b0;
   assign w_pc_inc    = (w_pc_plus4 >= MEM_BYTES) ? '0 : w_pc_plus4;
   assign fetch_fault = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_push      = 1'b0;
      case (r_state)
         IDLE: w_state_nxt = dbg_req ? DEBUG : FETCH;
         FETCH: begin
            if (!w_full && w_oob) begin
               w_state_nxt = HALT;
            end else begin
               if (!w_full) begin
                  w_push   = 1'b1;
                  w_pc_nxt = w_pc_inc;
               end
               // Debug takes the next cycle; the fetch in this cycle still completes.
               if (dbg_req) w_state_nxt = DEBUG;
            end
         end
         DEBUG:   w_state_nxt = FETCH;
         HALT:    w_state_nxt = HALT;
         default: w_state_nxt = IDLE;
      endcase
      if (redirect_valid) begin
         w_push   = 1'b0;
         w_pc_nxt = w_redirect_pc;
         if (r_state == HALT) w_state_nxt = FETCH;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dbg_rvalid <= 1'b0;
         r_dbg_rdata  <= '0;
      end else begin
         r_dbg_rvalid <= (r_state == DEBUG);
         if (r_state == DEBUG) r_dbg_rdata <= imem_instr;
      end
   end

   assign imem_adr   = (r_state == DEBUG) ? dbg_adr : r_pc;
   assign dbg_gnt    = (r_state == DEBUG);
   assign dbg_rvalid = r_dbg_rvalid;
   assign dbg_rdata  = r_dbg_rdata;
   assign w_entry_in = '{instr: imem_instr, pc: r_pc};

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .i_rst_n (reset),
      .i_push  (w_push),
      .i_data  (w_entry_in),
      .i_pop   (instr_ready && !w_empty),
      .i_flush (redirect_valid),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   assign instr_valid = !w_empty;
   assign instr_out   = w_head.instr;
   assign instr_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - scoreboard bench for fetch_controller (default build, or with FETCH_BOUNDS_CHECK_EN)
module tb_fetch_controller;

   localparam logic [63:0] MEM_BYTES = 64'd64;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] imem_adr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [63:0] instr_pc;
   logic        dbg_req;
   logic [63:0] dbg_adr;
   logic        dbg_gnt;
   logic        dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic        fetch_fault;

   int          n_vec  = 0;
   int          n_miss = 0;
   int          pop_cnt = 0;
   int          iters;
   logic [63:0] sb_q[$];
   logic [63:0] exp_pc;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[63:32] ^ a[31:0] ^ 32'hC0DE_0000;
   endfunction

   assign imem_instr = mem_word(imem_adr);

   fetch_controller #(
      .MEM_SIZE   (16),
      .RESET_PC   (64'h0),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_adr       (imem_adr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc),
      .dbg_req        (dbg_req),
      .dbg_adr        (dbg_adr),
      .dbg_gnt        (dbg_gnt),
      .dbg_rvalid     (dbg_rvalid),
      .dbg_rdata      (dbg_rdata),
      .fetch_fault    (fetch_fault)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input logic [63:0] start, input int n);
      logic [63:0] pc;
      pc = start;
      for (int i = 0; i < n; i++) begin
         sb_q.push_back(pc);
         pc = pc + 64'd4;
`ifndef FETCH_BOUNDS_CHECK_EN
         if (pc >= MEM_BYTES) pc = 64'd0;
`endif
      end
   endtask

   task automatic drain(input int n, input int budget, output int cycles);
      int target;
      target = pop_cnt + n;
      cycles = 0;
      while (pop_cnt < target && cycles < budget) begin
         cyc();
         cycles++;
      end
      check_eq("drain_count", 64'(pop_cnt), 64'(target));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      sb_q.delete();
      cyc();
      cyc();
      reset = 1'b1;
   endtask

   // Handshake is sampled mid-cycle; inputs only change just after the rising edge.
   always @(negedge clk) begin
      if (reset && instr_valid && instr_ready && !redirect_valid) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
         end else begin
            exp_pc = sb_q.pop_front();
            check_eq("instr_pc", instr_pc, exp_pc);
            check_eq("instr_out", 64'(instr_out), 64'(mem_word(exp_pc)));
         end
         pop_cnt++;
      end
   end

   initial begin
      reset          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      instr_ready    = 1'b1;
      dbg_req        = 1'b0;
      dbg_adr        = 64'h0;
      cyc();
      cyc();
      check_eq("rst_instr_valid", 64'(instr_valid), 64'd0);
      check_eq("rst_dbg_gnt", 64'(dbg_gnt), 64'd0);
      check_eq("rst_dbg_rvalid", 64'(dbg_rvalid), 64'd0);
      check_eq("rst_dbg_rdata", 64'(dbg_rdata), 64'd0);
      check_eq("rst_fetch_fault", 64'(fetch_fault), 64'd0);
      check_eq("rst_imem_adr", imem_adr, 64'h0);

      // sequential stream right after reset release
      push_seq(64'h0, 4);
      reset = 1'b1;
      drain(4, 20, iters);
      check_eq("startup_cycles", 64'(iters), 64'd6);
      instr_ready = 1'b0;

      // back-pressure: two entries fill the buffer and pc holds
      do_reset();
      instr_ready = 1'b0;
      repeat (5) cyc();
      check_eq("stall_imem_adr", imem_adr, 64'h8);
      check_eq("stall_valid", 64'(instr_valid), 64'd1);
      check_eq("stall_head_pc", instr_pc, 64'h0);
      push_seq(64'h0, 4);
      instr_ready = 1'b1;
      drain(4, 20, iters);
      instr_ready = 1'b0;

      // redirect (misaligned target) with a full buffer
      do_reset();
      instr_ready = 1'b0;
      repeat (3) cyc();
      check_eq("full_imem_adr", imem_adr, 64'h8);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h23;
      sb_q.delete();
      push_seq(64'h20, 4);
      cyc();
      redirect_valid = 1'b0;
      check_eq("flush_valid", 64'(instr_valid), 64'd0);
      check_eq("redir_imem_adr", imem_adr, 64'h20);
      instr_ready = 1'b1;
      drain(4, 20, iters);
      instr_ready = 1'b0;

      // debug reads interleave with fetch
      instr_ready = 1'b1;
      do_reset();
      push_seq(64'h0, 8);
      repeat (3) cyc();
      dbg_req = 1'b1;
      dbg_adr = 64'h8;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) dbg_req = 1'b0;
         #1;
         check_eq("dbg_gnt", 64'(dbg_gnt), ((i == 1) || (i == 3)) ? 64'd1 : 64'd0);
         check_eq("dbg_rvalid", 64'(dbg_rvalid), ((i == 2) || (i == 4)) ? 64'd1 : 64'd0);
         if (i == 1 || i == 3) check_eq("dbg_imem_adr", imem_adr, 64'h8);
         if (i == 2 || i == 4) check_eq("dbg_rdata", 64'(dbg_rdata), 64'(mem_word(64'h8)));
         if (i < 4) cyc();
      end
      drain(sb_q.size(), 40, iters);
      instr_ready = 1'b0;

      // end of memory
      instr_ready = 1'b1;
      do_reset();
`ifdef FETCH_BOUNDS_CHECK_EN
      push_seq(64'h0, 16);
      drain(16, 60, iters);
      cyc();
      check_eq("fault_set", 64'(fetch_fault), 64'd1);
      check_eq("halt_imem_adr", imem_adr, 64'h40);
      check_eq("halt_valid", 64'(instr_valid), 64'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0;
      push_seq(64'h0, 2);
      cyc();
      redirect_valid = 1'b0;
      check_eq("fault_clear", 64'(fetch_fault), 64'd0);
      drain(2, 20, iters);
`else
      push_seq(64'h0, 20);
      drain(20, 80, iters);
      check_eq("no_fault", 64'(fetch_fault), 64'd0);
`endif
      instr_ready = 1'b0;

      // asynchronous reset with two entries buffered
      do_reset();
      instr_ready = 1'b0;
      repeat (4) cyc();
      check_eq("pre_rst_valid", 64'(instr_valid), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      check_eq("async_rst_valid", 64'(instr_valid), 64'd0);
      check_eq("async_rst_imem_adr", imem_adr, 64'h0);
      cyc();
      sb_q.delete();
      push_seq(64'h0, 4);
      instr_ready = 1'b1;
      reset = 1'b1;
      drain(4, 20, iters);
      check_eq("restart_cycles", 64'(iters), 64'd6);
      instr_ready = 1'b0;
      repeat (2) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
